// File: rtl/iir_pkg.sv
// Shared types, FSM encoding and PCM saturation helper for the IIR
// sample sequencer.
package iir_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [39:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH_L = 2'd1,
        CH_R = 2'd2,
        CLR  = 2'd3
    } state_t;

    localparam int PCM_MAX = 32767;
    localparam int PCM_MIN = -32768;

    // Integer part is y[39:shift]; clamp it into PCM range.
    function automatic sample_t sat_pcm(acc_t y, int shift);
        acc_t v;
        v = y >>> shift;
        if (v > acc_t'(PCM_MAX))
            return sample_t'(PCM_MAX);
        else if (v < acc_t'(PCM_MIN))
            return sample_t'(PCM_MIN);
        else
            return sample_t'(v[15:0]);
    endfunction

endpackage

// File: rtl/iir_filter_seq_sat.sv
// Combinational 40-bit fixed point to 16-bit PCM saturator, shared
// between channels by timeslot.
module iir_filter_seq_sat
    import iir_pkg::*;
#(
    parameter int SHIFT = 22
) (
    input  acc_t    y,
    output sample_t q
);

    assign q = sat_pcm(y, SHIFT);

endmodule

// File: rtl/iir_filter_seq.sv
// Stereo sequencer: time-multiplexes left/right onto the tap chain,
// forms y = x + tap0 and presents saturated PCM downstream.
module iir_filter_seq
    import iir_pkg::*;
#(
    parameter int SHIFT = 22,
    parameter int PCM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PCM_W-1:0] in_l,
    input  logic [PCM_W-1:0] in_r,
    input  logic             flush,
    output logic             tap_ce,
    output logic             tap_ch,
    output logic             tap_clr,
    output logic [39:0]      tap_x,
    output logic [39:0]      tap_y,
    input  logic [39:0]      tap0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PCM_W-1:0] out_l,
    output logic [PCM_W-1:0] out_r
);

    state_t  state;
    sample_t lat_l;
    sample_t lat_r;
    sample_t hold_l;
    sample_t sat_q;
    logic    accept;

    always_comb begin
        tap_x = '0;
        unique case (state)
            CH_L:    tap_x = acc_t'(lat_l) <<< SHIFT;
            CH_R:    tap_x = acc_t'(lat_r) <<< SHIFT;
            default: tap_x = '0;
        endcase
    end

    assign tap_y = tap_x + tap0;

    iir_filter_seq_sat #(
        .SHIFT(SHIFT)
    ) u_sat (
        .y(acc_t'(tap_y)),
        .q(sat_q)
    );

    // Registered out_valid only: a same-cycle out_ready does not open input.
    assign in_ready = reset_n && (state == IDLE)
                   && !out_valid && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_l     <= '0;
            lat_r     <= '0;
            hold_l    <= '0;
            tap_ce    <= 1'b0;
            tap_ch    <= 1'b0;
            tap_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
        end else begin
            tap_clr <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        state   <= CLR;
                        tap_clr <= 1'b1;
                    end else if (accept) begin
                        lat_l  <= in_l;
                        lat_r  <= in_r;
                        state  <= CH_L;
                        tap_ce <= 1'b1;
                        tap_ch <= 1'b0;
                    end
                end
                CH_L: begin
                    hold_l <= sat_q;
                    state  <= CH_R;
                    tap_ch <= 1'b1;
                end
                CH_R: begin
                    out_l     <= hold_l;
                    out_r     <= sat_q;
                    out_valid <= 1'b1;
                    tap_ce    <= 1'b0;
                    state     <= IDLE;
                end
                CLR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_filter_seq.sv
// Scoreboard bench for iir_filter_seq: reset, passthrough, saturation,
// backpressure, flush and reset during the right-channel slot.
module tb_iir_filter_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        flush;
    logic        tap_ce;
    logic        tap_ch;
    logic        tap_clr;
    logic [39:0] tap_x;
    logic [39:0] tap_y;
    logic [39:0] tap0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_l;
    logic [15:0] out_r;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    longint nt0_l = 0, nt0_r = 0;
    longint cur_t0_l = 0, cur_t0_r = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic        prev_ov = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tap0 = tap_ch ? 40'(cur_t0_r) : 40'(cur_t0_l);

    iir_filter_seq dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .flush(flush),
        .tap_ce(tap_ce), .tap_ch(tap_ch), .tap_clr(tap_clr),
        .tap_x(tap_x), .tap_y(tap_y), .tap0(tap0),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r)
    );

    task automatic check(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(logic [15:0] x, longint t0);
        longint y;
        longint v;
        y = longint'($signed(x)) * 64'sd4194304 + t0;
        v = y >>> 22;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic longint xsc(logic [15:0] x);
        logic [39:0] w;
        w = 40'(longint'($signed(x)) * 64'sd4194304);
        return longint'(w);
    endfunction

    // Scoreboard monitor: push at accept, pop at output transfer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back({model(in_l, nt0_l), model(in_r, nt0_r)});
                acc_q.push_back(cyc);
                cur_t0_l = nt0_l;
                cur_t0_r = nt0_r;
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0)
                    check("lat_unexp", 1, 0);
                else
                    check("latency", cyc - acc_q.pop_front(), 3);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_l", out_l, e[31:16]);
                    check("out_r", out_r, e[15:0]);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(logic [15:0] l, logic [15:0] r,
                        longint tl, longint tr);
        logic ok;
        in_l = l;
        in_r = r;
        nt0_l = tl;
        nt0_r = tr;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] hl, hr;
        logic ok;
        reset_n = 1'b0;
        in_valid = 1'b1;
        in_l = 16'h1234;
        in_r = 16'hF000;
        flush = 1'b0;
        out_ready = 1'b1;

        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_tap_ce", tap_ce, 0);
            check("rst_out_l", out_l, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("first_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("chl_ce", tap_ce, 1);
        check("chl_ch", tap_ch, 0);
        check("chl_x", tap_x, xsc(16'h1234));
        @(negedge clk);
        check("chr_ce", tap_ce, 1);
        check("chr_ch", tap_ch, 1);
        check("chr_x", tap_x, xsc(16'hF000));
        @(negedge clk);
        check("pt_ov", out_valid, 1);
        check("idle_x", tap_x, 0);
        repeat (3) @(negedge clk);

        send(16'h7FFF, 16'h8000, 64'sd1 <<< 37, -(64'sd1 <<< 37));
        repeat (4) @(negedge clk);
        send(16'h7FFF, 16'h0001, 0, 0);
        repeat (4) @(negedge clk);
        send(16'd100, -16'sd200, 64'sd5 <<< 22, -(64'sd3 <<< 22));
        repeat (4) @(negedge clk);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'h0101, 16'h0202, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_ov", ok, 1);
        hl = out_l;
        hr = out_r;
        @(posedge clk);
        #1;
        in_l = 16'h0303;
        in_r = 16'h0404;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_l", out_l, hl);
            check("bp_r", out_r, hr);
            check("bp_ov_hold", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_tap_ce", tap_ce, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'h0303, 16'h0404, 0, 0);
        repeat (5) @(negedge clk);

        @(posedge clk);
        #1;
        nt0_l = 0;
        nt0_r = 0;
        in_l = 16'h0055;
        in_r = 16'hFFAA;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_clr", tap_clr, 1);
        check("fl_ce", tap_ce, 0);
        check("fl_no_take", exp_q.size(), 0);
        @(negedge clk);
        check("fl_clr_end", tap_clr, 0);
        check("fl_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);

        send(16'h4000, 16'h2000, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("rr_chr_ce", tap_ce, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rr_ce", tap_ce, 0);
        check("rr_ch", tap_ch, 0);
        check("rr_ov", out_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rr_no_ov", out_valid, 0);
        end

        repeat (2) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
